// File: rtl/ans_out_packer.sv
// Packs 4-bit ANS symbols pairwise into bytes and queues them in a small FIFO.
// Optional symbol counter output enabled by defining ANS_PACKER_CNT_EN.
module ans_out_packer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [3:0]  in,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic        flush,
    output logic [7:0]  out,
    output logic        out_pad,
    output logic        out_vld,
    input  logic        out_rdy
`ifdef ANS_PACKER_CNT_EN
    ,
    output logic [15:0] sym_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_half;
    logic [3:0]    r_held;
    logic          r_flush_pend;

    logic          w_full;
    logic          w_live;
    logic          w_in_rdy;
    logic          w_acc;
    logic          w_flush_any;
    logic          w_pop;
    logic          w_push;
    logic [8:0]    w_push_data;
    logic          w_half_nxt;
    logic [3:0]    w_held_nxt;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_live      = (r_count != '0) & ~rst;
    assign w_in_rdy    = ena & ~rst & (~r_half | ~w_full);
    assign w_acc       = in_vld & w_in_rdy;
    assign w_flush_any = flush | r_flush_pend;
    assign w_pop       = ena & w_live & out_rdy;

    assign in_rdy  = w_in_rdy;
    assign out_vld = ena & w_live;
    assign out     = w_live ? r_mem[r_rd_ptr][7:0] : 8'h00;
    assign out_pad = w_live ? r_mem[r_rd_ptr][8]   : 1'b0;

    // A lone symbol accepted while the FIFO is full is held instead of being
    // flushed; the pending flush then emits it once space frees up.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = 9'h000;
        w_half_nxt  = r_half;
        w_held_nxt  = r_held;
        if (w_acc) begin
            if (r_half) begin
                w_push      = 1'b1;
                w_push_data = {1'b0, in, r_held};
                w_half_nxt  = 1'b0;
            end else if (w_flush_any && !w_full) begin
                w_push      = 1'b1;
                w_push_data = {1'b1, 4'h0, in};
            end else begin
                w_half_nxt  = 1'b1;
                w_held_nxt  = in;
            end
        end else if (ena && !rst && r_half && w_flush_any && !w_full) begin
            w_push      = 1'b1;
            w_push_data = {1'b1, 4'h0, r_held};
            w_half_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_half       <= 1'b0;
            r_held       <= 4'h0;
            r_flush_pend <= 1'b0;
        end else if (ena) begin
            r_half       <= w_half_nxt;
            r_held       <= w_held_nxt;
            r_flush_pend <= w_flush_any & w_half_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

`ifdef ANS_PACKER_CNT_EN
    logic [15:0] r_sym_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sym_count <= 16'h0000;
        end else if (w_acc && r_sym_count != 16'hFFFF) begin
            r_sym_count <= r_sym_count + 16'h0001;
        end
    end

    assign sym_count = r_sym_count;
`endif

endmodule

// File: tb/tb_ans_out_packer.sv
// Bench for ans_out_packer: directed scenarios plus random traffic against a
// queue-based reference of the packing rules.
module tb_ans_out_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  in;
    logic        in_vld;
    logic        in_rdy;
    logic        flush;
    logic [7:0]  out;
    logic        out_pad;
    logic        out_vld;
    logic        out_rdy;
`ifdef ANS_PACKER_CNT_EN
    logic [15:0] sym_count;
`endif

    ans_out_packer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .in      (in),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .flush   (flush),
        .out     (out),
        .out_pad (out_pad),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
`ifdef ANS_PACKER_CNT_EN
        ,
        .sym_count (sym_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state: queued {pad,byte} entries, held nibble, pending flush
    bit [8:0]   q[$];
    bit         m_half;
    bit [3:0]   m_held;
    bit         m_fpend;
    int         m_sym;
    bit         m_acc;
    logic [7:0] popped[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit live;
        live = (q.size() != 0) && !rst;
        chk("in_rdy",  in_rdy,  ena && !rst && (!m_half || q.size() != DEPTH));
        chk("out_vld", out_vld, ena && live);
        chk("out",     out,     live ? q[0][7:0] : 8'h00);
        chk("out_pad", out_pad, live ? q[0][8] : 1'b0);
`ifdef ANS_PACKER_CNT_EN
        chk("sym_count", sym_count, (m_sym > 65535) ? 16'hFFFF : m_sym[15:0]);
`endif
    endtask

    task automatic model_step();
        bit full, acc, pop, fl;
        m_acc = 0;
        if (rst) begin
            q.delete();
            m_half  = 0;
            m_held  = 0;
            m_fpend = 0;
            m_sym   = 0;
            return;
        end
        if (!ena) return;
        full = (q.size() == DEPTH);
        acc  = in_vld && (!m_half || !full);
        pop  = (q.size() != 0) && out_rdy;
        fl   = flush || m_fpend;
        if (pop) void'(q.pop_front());
        if (acc) begin
            m_sym++;
            if (m_half) begin
                q.push_back({1'b0, in, m_held});
                m_half = 0;
            end else if (fl && !full) begin
                q.push_back({1'b1, 4'h0, in});
            end else begin
                m_half = 1;
                m_held = in;
            end
        end else if (m_half && fl && !full) begin
            q.push_back({1'b1, 4'h0, m_held});
            m_half = 0;
        end
        m_fpend = fl && m_half;
        m_acc   = acc;
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        if (!rst && ena && out_vld && out_rdy) popped.push_back(out);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sym);
        bit done;
        done   = 0;
        in     = sym;
        in_vld = 1;
        for (int k = 0; k < 100 && !done; k++) begin
            cycle();
            done = m_acc;
        end
        in_vld = 0;
        chk("send_timeout", done, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        logic [7:0] exp_bytes [5];
        bit done;
        rst = 1; ena = 1; in = 0; in_vld = 0; flush = 0; out_rdy = 0;
        @(posedge clk);
        #1;
        m_half = 0; m_held = 0; m_fpend = 0; m_sym = 0;
        chk("rst_in_rdy",  in_rdy,  1'b0);
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_out",     out,     8'h00);
        chk("rst_out_pad", out_pad, 1'b0);
        rst = 0;

        // pairing 3 then A -> A3
        send(4'h3);
        send(4'hA);
        cycle();
        chk("pair_byte", out, 8'hA3);
        chk("pair_pad",  out_pad, 1'b0);
        out_rdy = 1;
        cycle();
        out_rdy = 0;
        chk("pair_single", out_vld, 1'b0);

        // odd flush
        send(4'h5);
        flush = 1;
        cycle();
        flush = 0;
        cycle();
        chk("odd_byte", out, 8'h05);
        chk("odd_pad",  out_pad, 1'b1);
        out_rdy = 1;
        cycle();
        out_rdy = 0;
        flush = 1;
        cycle();
        flush = 0;
        cycle();
        chk("flush_noop", out_vld, 1'b0);

        // backpressure: 9 symbols fill 4 bytes and hold one nibble
        popped.delete();
        for (int i = 1; i <= 9; i++) send(4'(i));
        cycle();
        chk("bp_in_rdy", in_rdy, 1'b0);
        chk("bp_head",   out, 8'h21);
        in = 4'hA; in_vld = 1; out_rdy = 1;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            done = m_acc;
        end
        chk("bp_accept", done, 1'b1);
        in_vld = 0;
        repeat (8) cycle();
        exp_bytes = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9};
        chk("bp_count", 16'(popped.size()), 16'd5);
        for (int i = 0; i < 5; i++)
            chk("bp_order", (i < popped.size()) ? popped[i] : 8'hxx, exp_bytes[i]);
        out_rdy = 0;

        // full FIFO with simultaneous push/pop streaming
        for (int i = 0; i < 9; i++) send(4'($urandom_range(0, 15)));
        out_rdy = 1; in_vld = 1;
        for (int k = 0; k < 24; k++) begin
            in = 4'($urandom_range(0, 15));
            cycle();
        end
        in_vld = 0;
        repeat (8) cycle();
        out_rdy = 0;

        // reset mid-stream
        for (int i = 0; i < 5; i++) send(4'hF);
        do_reset();
        #1;
        chk("mid_rst_vld", out_vld, 1'b0);
        send(4'h1);
        send(4'h2);
        cycle();
        chk("mid_rst_byte", out, 8'h21);
        chk("mid_rst_pad",  out_pad, 1'b0);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            ena     = ($urandom_range(0, 15) != 0);
            in      = 4'($urandom_range(0, 15));
            in_vld  = $urandom_range(0, 1);
            flush   = ($urandom_range(0, 7) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 0; ena = 1; flush = 0; in_vld = 0;

`ifdef ANS_PACKER_CNT_EN
        do_reset();
        out_rdy = 1; in_vld = 1;
        for (int k = 0; k < 80000 && m_sym < 70000; k++) begin
            in = 4'(k);
            cycle();
        end
        in_vld = 0;
        cycle();
        chk("cnt_sat", sym_count, 16'hFFFF);
        do_reset();
        #1;
        chk("cnt_rst", sym_count, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
